// File: rtl/sd_cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// sd_cmd_arbiter_if
// Purpose : bundles the command-path signals exchanged between the
//           sd_cmd_arbiter and the sd_cmd_master it drives.
// Signals :
//   new_cmd_o     arbiter -> master  New_CMD strobe
//   arg_o         arbiter -> master  ARG_REG image (32)
//   cmdset_o      arbiter -> master  CMD_SET_REG image (14)
//   data_read_o   arbiter -> master  data_read
//   data_write_o  arbiter -> master  data_write
//   cicmd_i       master -> arbiter  STATUS_REG[0] (command in progress)
//   nint_i        master -> arbiter  NORMAL_INT_REG ([0]=CC, [15]=EI)
//   eint_i        master -> arbiter  ERR_INT_REG (5)
//   resp_i        master -> arbiter  RESP_1_REG (32)
// Modports: master = arbiter side, slave = sd_cmd_master side.
// ---------------------------------------------------------------------------
interface sd_cmd_arbiter_if;
    logic        new_cmd_o;
    logic [31:0] arg_o;
    logic [13:0] cmdset_o;
    logic        data_read_o;
    logic        data_write_o;
    logic        cicmd_i;
    logic [15:0] nint_i;
    logic [4:0]  eint_i;
    logic [31:0] resp_i;

    modport master (
        output new_cmd_o, arg_o, cmdset_o, data_read_o, data_write_o,
        input  cicmd_i, nint_i, eint_i, resp_i
    );

    modport slave (
        input  new_cmd_o, arg_o, cmdset_o, data_read_o, data_write_o,
        output cicmd_i, nint_i, eint_i, resp_i
    );
endinterface

// File: rtl/sd_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// sd_cmd_arbiter
// Purpose : shares the single sd_cmd_master command path between port A
//           (host register path) and port B (internal auto-command source).
//           The granted request is latched onto the master, the command is
//           tracked through CICMD and the completion/response/error flags
//           are returned to the owning port only.
// Ports   :
//   CLK_PAD_IO, RST_PAD_I        clock, synchronous active-high reset
//   a_req_i/a_arg_i/a_cmdset_i/a_rd_i/a_wr_i, a_done_o   port A
//   b_req_i/b_arg_i/b_cmdset_i/b_rd_i/b_wr_i, b_done_o   port B
//   bus (sd_cmd_arbiter_if.master)  command path to sd_cmd_master
//   resp_o   captured response, err_o {start_timeout, eint[4:0]}
//   busy_o   state != IDLE, tag_o grant counter (wraps)
// Parameters: START_TO start timeout in cycles, ID_W width of tag_o.
// Configuration macro: SD_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin on a tie (first tie after reset goes to B)
//   undefined -> fixed priority, B wins every tie
// ---------------------------------------------------------------------------
module sd_cmd_arbiter #(
    parameter logic [15:0] START_TO = 16'd1023,
    parameter int          ID_W     = 2
) (
    input  logic              CLK_PAD_IO,
    input  logic              RST_PAD_I,
    input  logic              a_req_i,
    input  logic [31:0]       a_arg_i,
    input  logic [13:0]       a_cmdset_i,
    input  logic              a_rd_i,
    input  logic              a_wr_i,
    output logic              a_done_o,
    input  logic              b_req_i,
    input  logic [31:0]       b_arg_i,
    input  logic [13:0]       b_cmdset_i,
    input  logic              b_rd_i,
    input  logic              b_wr_i,
    output logic              b_done_o,
    sd_cmd_arbiter_if.master  bus,
    output logic [31:0]       resp_o,
    output logic [5:0]        err_o,
    output logic              busy_o,
    output logic [ID_W-1:0]   tag_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t          r_state;
    logic [15:0]     r_cnt;
    logic            r_last_b;
    logic            r_owner_b;
    logic            r_new_cmd;
    logic [31:0]     r_arg;
    logic [13:0]     r_cmdset;
    logic            r_rd;
    logic            r_wr;
    logic            r_a_done;
    logic            r_b_done;
    logic [31:0]     r_resp;
    logic [5:0]      r_err;
    logic            r_busy;
    logic [ID_W-1:0] r_tag;

    logic            w_any_req;
    logic            w_grant_b;
    logic            w_no_result;
    logic [15:0]     w_cnt_next;

    // Grant selection and completion qualifiers.
    always_comb begin
        w_any_req   = a_req_i | b_req_i;
        // Neither CC nor EI set when CICMD drops means the master aborted.
        w_no_result = ~nint_i_cc() & ~nint_i_ei();
        w_cnt_next  = r_cnt + 16'd1;
        if (a_req_i && b_req_i) begin
`ifdef SD_ARB_ROUND_ROBIN_EN
            w_grant_b = ~r_last_b;
`else
            w_grant_b = 1'b1;
`endif
        end else begin
            w_grant_b = b_req_i;
        end
    end

    function automatic logic nint_i_cc();
        return bus.nint_i[0];
    endfunction

    function automatic logic nint_i_ei();
        return bus.nint_i[15];
    endfunction

    // Command FSM with all outputs registered.
    always_ff @(posedge CLK_PAD_IO) begin
        if (RST_PAD_I) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 16'd0;
            r_last_b  <= 1'b0;
            r_owner_b <= 1'b0;
            r_new_cmd <= 1'b0;
            r_arg     <= 32'd0;
            r_cmdset  <= 14'd0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_a_done  <= 1'b0;
            r_b_done  <= 1'b0;
            r_resp    <= 32'd0;
            r_err     <= 6'd0;
            r_busy    <= 1'b0;
            r_tag     <= '0;
        end else begin
            r_a_done <= 1'b0;
            r_b_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner_b <= w_grant_b;
                        r_last_b  <= w_grant_b;
                        r_arg     <= w_grant_b ? b_arg_i    : a_arg_i;
                        r_cmdset  <= w_grant_b ? b_cmdset_i : a_cmdset_i;
                        r_rd      <= w_grant_b ? b_rd_i     : a_rd_i;
                        r_wr      <= w_grant_b ? b_wr_i     : a_wr_i;
                        r_new_cmd <= 1'b1;
                        r_tag     <= r_tag + ID_W'(1);
                        r_cnt     <= 16'd0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end else begin
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // CICMD wins over a timeout that expires on the same edge.
                    if (bus.cicmd_i) begin
                        r_new_cmd <= 1'b0;
                        r_state   <= ST_RUN;
                    end else if (w_cnt_next >= START_TO) begin
                        r_new_cmd <= 1'b0;
                        r_err     <= 6'b100000;
                        r_a_done  <= ~r_owner_b;
                        r_b_done  <= r_owner_b;
                        r_state   <= ST_FINISH;
                    end else begin
                        r_cnt     <= w_cnt_next;
                    end
                end
                ST_RUN: begin
                    if (!bus.cicmd_i) begin
                        r_resp   <= bus.resp_i;
                        r_err    <= {w_no_result, bus.eint_i};
                        r_a_done <= ~r_owner_b;
                        r_b_done <= r_owner_b;
                        r_state  <= ST_FINISH;
                    end else begin
                        r_state  <= ST_RUN;
                    end
                end
                ST_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_new_cmd <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.new_cmd_o    = r_new_cmd;
    assign bus.arg_o        = r_arg;
    assign bus.cmdset_o     = r_cmdset;
    assign bus.data_read_o  = r_rd;
    assign bus.data_write_o = r_wr;
    assign a_done_o         = r_a_done;
    assign b_done_o         = r_b_done;
    assign resp_o           = r_resp;
    assign err_o            = r_err;
    assign busy_o           = r_busy;
    assign tag_o            = r_tag;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sd_cmd_arbiter
// Self-checking bench for sd_cmd_arbiter: a table of single-port commands
// plus hand-written sequences for reset, tie-break and back-to-back grants.
// The bench plays the sd_cmd_master side of the interface.
// ---------------------------------------------------------------------------
module tb_sd_cmd_arbiter;

    localparam logic [15:0] START_TO = 16'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req_i, a_rd_i, a_wr_i, a_done_o;
    logic [31:0] a_arg_i;
    logic [13:0] a_cmdset_i;
    logic        b_req_i, b_rd_i, b_wr_i, b_done_o;
    logic [31:0] b_arg_i;
    logic [13:0] b_cmdset_i;
    logic [31:0] resp_o;
    logic [5:0]  err_o;
    logic        busy_o;
    logic [1:0]  tag_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  exp_tag  = 2'd0;

    sd_cmd_arbiter_if bus();

    sd_cmd_arbiter #(.START_TO(START_TO), .ID_W(2)) dut (
        .CLK_PAD_IO (clk),
        .RST_PAD_I  (rst),
        .a_req_i    (a_req_i),
        .a_arg_i    (a_arg_i),
        .a_cmdset_i (a_cmdset_i),
        .a_rd_i     (a_rd_i),
        .a_wr_i     (a_wr_i),
        .a_done_o   (a_done_o),
        .b_req_i    (b_req_i),
        .b_arg_i    (b_arg_i),
        .b_cmdset_i (b_cmdset_i),
        .b_rd_i     (b_rd_i),
        .b_wr_i     (b_wr_i),
        .b_done_o   (b_done_o),
        .bus        (bus.master),
        .resp_o     (resp_o),
        .err_o      (err_o),
        .busy_o     (busy_o),
        .tag_o      (tag_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port_b;
        logic [31:0] arg;
        logic [13:0] cmdset;
        logic        rd;
        logic        wr;
        int          delay;   // cycles from new_cmd to cicmd rise, <0 = never
        int          hold;    // cycles cicmd stays high
        logic [15:0] nint;
        logic [4:0]  eint;
        logic [31:0] resp;
        logic [5:0]  exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_port(input bit pb, input logic [31:0] arg, input logic [13:0] cs,
                            input logic rd, input logic wr);
        if (pb) begin
            b_arg_i = arg; b_cmdset_i = cs; b_rd_i = rd; b_wr_i = wr; b_req_i = 1'b1;
        end else begin
            a_arg_i = arg; a_cmdset_i = cs; a_rd_i = rd; a_wr_i = wr; a_req_i = 1'b1;
        end
    endtask

    // Wait for the grant, play the master, check completion on the owning port.
    task automatic serve(input bit exp_b, input int delay, input int hold,
                         input logic [15:0] nint, input logic [4:0] eint,
                         input logic [31:0] resp, input logic [5:0] exp_err,
                         input bit raise_b);
        int          w;
        int          hi;
        int          d;
        bit          got;
        logic [31:0] e_arg;
        logic [13:0] e_cs;
        logic [1:0]  e_rw;
        e_arg = exp_b ? b_arg_i : a_arg_i;
        e_cs  = exp_b ? b_cmdset_i : a_cmdset_i;
        e_rw  = exp_b ? {b_rd_i, b_wr_i} : {a_rd_i, a_wr_i};
        w = 0;
        got = 1'b0;
        while (!got && w < 10) begin
            @(negedge clk);
            w++;
            got = bus.new_cmd_o;
        end
        check("grant_latency", 64'(w), 64'd1);
        if (!got) begin
            a_req_i = 1'b0;
            b_req_i = 1'b0;
            return;
        end
        exp_tag = exp_tag + 2'd1;
        check("arg_o", 64'(bus.arg_o), 64'(e_arg));
        check("cmdset_o", 64'(bus.cmdset_o), 64'(e_cs));
        check("rd_wr", 64'({bus.data_read_o, bus.data_write_o}), 64'(e_rw));
        check("tag_o", 64'(tag_o), 64'(exp_tag));
        check("busy_grant", 64'(busy_o), 64'd1);
        if (delay < 0) begin
            hi = 1;
            while (bus.new_cmd_o && hi < 40) begin
                @(negedge clk);
                if (bus.new_cmd_o) hi++;
            end
            check("newcmd_high_cycles", 64'(hi), 64'(START_TO));
        end else begin
            repeat (delay) @(negedge clk);
            check("newcmd_held", 64'(bus.new_cmd_o), 64'd1);
            bus.cicmd_i = 1'b1;
            @(negedge clk);
            check("newcmd_drop", 64'(bus.new_cmd_o), 64'd0);
            if (raise_b) b_req_i = 1'b1;
            repeat (hold - 1) @(negedge clk);
            check("no_early_done", 64'({a_done_o, b_done_o}), 64'd0);
            bus.nint_i  = nint;
            bus.eint_i  = eint;
            bus.resp_i  = resp;
            bus.cicmd_i = 1'b0;
            @(negedge clk);
        end
        d = 0;
        while (!(exp_b ? b_done_o : a_done_o) && d < 10) begin
            @(negedge clk);
            d++;
        end
        check("done_pulse", 64'(exp_b ? b_done_o : a_done_o), 64'd1);
        check("other_done", 64'(exp_b ? a_done_o : b_done_o), 64'd0);
        check("err_o", 64'(err_o), 64'(exp_err));
        if (delay >= 0) check("resp_o", 64'(resp_o), 64'(resp));
        if (exp_b) b_req_i = 1'b0; else a_req_i = 1'b0;
        bus.nint_i = 16'd0;
        bus.eint_i = 5'd0;
        @(negedge clk);
        check("done_single", 64'({a_done_o, b_done_o}), 64'd0);
        check("idle_no_newcmd", 64'(bus.new_cmd_o), 64'd0);
        check("busy_idle", 64'(busy_o), 64'd0);
    endtask

    initial begin
        int  w;
        int  pulses;
        bit  second_b;

        tbl[0] = '{1'b0, 32'h0000_01AA, 14'h0819, 1'b0, 1'b0, 3, 20, 16'h0001, 5'b00000, 32'h0000_0900, 6'b000000};
        tbl[1] = '{1'b0, 32'h0000_0000, 14'h0C00, 1'b0, 1'b0, -1, 0, 16'h0000, 5'b00000, 32'h0, 6'b100000};
        tbl[2] = '{1'b1, 32'h1234_0000, 14'h0D1A, 1'b0, 1'b0, 1, 4, 16'h8000, 5'b00010, 32'hDEAD_BEEF, 6'b000010};
        tbl[3] = '{1'b0, 32'h0000_0200, 14'h1139, 1'b1, 1'b0, 2, 3, 16'h0000, 5'b00000, 32'h5555_AAAA, 6'b100000};
        tbl[4] = '{1'b1, 32'hFFFF_FFFF, 14'h3FFF, 1'b0, 1'b1, 7, 1, 16'h0001, 5'b10101, 32'h0BAD_F00D, 6'b010101};
        tbl[5] = '{1'b0, 32'hA5A5_5A5A, 14'h2AAA, 1'b1, 1'b1, 1, 1, 16'h8001, 5'b11111, 32'h0000_0001, 6'b011111};

        rst = 1'b1;
        a_req_i = 1'b0; a_arg_i = 32'd0; a_cmdset_i = 14'd0; a_rd_i = 1'b0; a_wr_i = 1'b0;
        b_req_i = 1'b0; b_arg_i = 32'd0; b_cmdset_i = 14'd0; b_rd_i = 1'b0; b_wr_i = 1'b0;
        bus.cicmd_i = 1'b0; bus.nint_i = 16'd0; bus.eint_i = 5'd0; bus.resp_i = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_newcmd", 64'(bus.new_cmd_o), 64'd0);
        check("rst_arg", 64'(bus.arg_o), 64'd0);
        check("rst_outs", 64'({a_done_o, b_done_o, busy_o, tag_o, err_o}), 64'd0);
        check("rst_resp", 64'(resp_o), 64'd0);
        rst = 1'b0;

        // Reset in the middle of RUN: no done pulse, back to idle at once.
        set_port(1'b0, 32'h0000_0777, 14'h0123, 1'b0, 1'b0);
        w = 0;
        while (!bus.new_cmd_o && w < 10) begin @(negedge clk); w++; end
        check("rst_seq_grant", 64'(bus.new_cmd_o), 64'd1);
        repeat (2) @(negedge clk);
        bus.cicmd_i = 1'b1;
        @(negedge clk);
        check("rst_seq_run", 64'({bus.new_cmd_o, busy_o}), 64'b01);
        @(negedge clk);
        rst = 1'b1; a_req_i = 1'b0; bus.cicmd_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_busy", 64'(busy_o), 64'd0);
        check("midrun_newcmd", 64'(bus.new_cmd_o), 64'd0);
        check("midrun_tag", 64'(tag_o), 64'd0);
        exp_tag = 2'd0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_done_o || b_done_o) pulses++;
        end
        check("midrun_no_done", 64'(pulses), 64'd0);

        // Tie-break: both high on the same edge, twice.
`ifdef SD_ARB_ROUND_ROBIN_EN
        second_b = 1'b0;
`else
        second_b = 1'b1;
`endif
        set_port(1'b0, 32'h0000_AAAA, 14'h0A0A, 1'b1, 1'b0);
        set_port(1'b1, 32'h0000_BBBB, 14'h0B0B, 1'b0, 1'b1);
        serve(1'b1, 1, 2, 16'h0001, 5'b00000, 32'h0000_00B1, 6'b000000, 1'b0);
        set_port(1'b1, 32'h0000_BBB2, 14'h0B02, 1'b0, 1'b0);
        serve(second_b, 2, 2, 16'h0001, 5'b00000, 32'h0000_00C2, 6'b000000, 1'b0);
        serve(!second_b, 1, 1, 16'h0001, 5'b00000, 32'h0000_00C3, 6'b000000, 1'b0);

        // Table of single-port commands.
        for (int i = 0; i < 6; i++) begin
            set_port(tbl[i].port_b, tbl[i].arg, tbl[i].cmdset, tbl[i].rd, tbl[i].wr);
            serve(tbl[i].port_b, tbl[i].delay, tbl[i].hold, tbl[i].nint, tbl[i].eint,
                  tbl[i].resp, tbl[i].exp_err, 1'b0);
        end

        // B raises its request while A is in RUN; B waits for A's done.
        b_arg_i = 32'h0000_0C0C; b_cmdset_i = 14'h0C0C; b_rd_i = 1'b1; b_wr_i = 1'b0;
        set_port(1'b0, 32'h0000_0D0D, 14'h0D0D, 1'b0, 1'b1);
        serve(1'b0, 2, 5, 16'h0001, 5'b00000, 32'h1111_2222, 6'b000000, 1'b1);
        serve(1'b1, 2, 2, 16'h0001, 5'b00100, 32'h3333_4444, 6'b000100, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
